// File: rtl/loop_stride_addr_gen_if.sv
// rtl/loop_stride_addr_gen_if.sv - loop event and address stream bundle between loop controller, address generator and consumer
interface loop_stride_addr_gen_if #(
    parameter int LOOP_ID_W = 5,
    parameter int ADDR_W    = 32
);
    logic [LOOP_ID_W-1:0] loop_index;
    logic                 loop_index_valid;
    logic                 loop_init;
    logic                 loop_enter;
    logic                 loop_exit;
    logic                 loop_last_iter;
    logic                 stall;
    logic [ADDR_W-1:0]    addr_out;
    logic                 addr_out_v;
    logic                 addr_out_ready;

    // master: controller events plus consumer ready; slave: the address generator
    modport master (
        output loop_index, loop_index_valid, loop_init, loop_enter, loop_exit,
               loop_last_iter, addr_out_ready,
        input  stall, addr_out, addr_out_v
    );

    modport slave (
        input  loop_index, loop_index_valid, loop_init, loop_enter, loop_exit,
               loop_last_iter, addr_out_ready,
        output stall, addr_out, addr_out_v
    );
endinterface

// File: rtl/loop_stride_addr_gen.sv
// rtl/loop_stride_addr_gen.sv - strided address generator driven by loop controller events
// Optional bounds/wrap checking built when ADDR_BOUNDS_CHECK_EN is defined.
module loop_stride_addr_gen #(
    parameter int LOOP_ID_W = 5,
    parameter int ADDR_W    = 32,
    parameter int STRIDE_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_base_addr_v,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    input  logic                 cfg_stride_v,
    input  logic [STRIDE_W-1:0]  cfg_stride,
    input  logic [LOOP_ID_W-1:0] cfg_stride_loop_id,
`ifdef ADDR_BOUNDS_CHECK_EN
    input  logic                 cfg_addr_limit_v,
    input  logic [ADDR_W-1:0]    cfg_addr_limit,
    output logic                 addr_oob,
`endif
    loop_stride_addr_gen_if.slave lp
);
    localparam int NUM_LOOPS = 1 << LOOP_ID_W;
`ifdef ADDR_BOUNDS_CHECK_EN
    localparam int SUM_W = ADDR_W + 1;
`else
    localparam int SUM_W = ADDR_W;
`endif

    logic [STRIDE_W-1:0]  stride_q [NUM_LOOPS];
    logic [ADDR_W-1:0]    cur_q    [NUM_LOOPS];
    logic [ADDR_W-1:0]    cur_d    [NUM_LOOPS];
    logic [ADDR_W-1:0]    base_q;

    logic [LOOP_ID_W-1:0] k;
    logic [LOOP_ID_W-1:0] km1;
    logic                 k_nz;
    logic [ADDR_W-1:0]    sext_k;
    logic [ADDR_W-1:0]    sext_0;
    logic [SUM_W-1:0]     sum_k;
    logic [SUM_W-1:0]     sum_0;
    logic                 inc_0;
    logic                 inc_k;

    assign lp.addr_out   = cur_q[0];
    // gated by reset so the valid drops the moment reset asserts
    assign lp.addr_out_v = lp.loop_index_valid & ~reset;
    assign lp.stall      = lp.addr_out_v & ~lp.addr_out_ready;

    always_comb begin
        k      = lp.loop_index;
        km1    = k - LOOP_ID_W'(1);
        k_nz   = |k;
        sext_k = {{(ADDR_W-STRIDE_W){stride_q[k][STRIDE_W-1]}}, stride_q[k]};
        sext_0 = {{(ADDR_W-STRIDE_W){stride_q[0][STRIDE_W-1]}}, stride_q[0]};
        sum_k  = SUM_W'(cur_q[k]) + SUM_W'(sext_k);
        sum_0  = SUM_W'(cur_q[0]) + SUM_W'(sext_0);
        inc_0  = lp.loop_index_valid & lp.addr_out_ready & ~lp.loop_last_iter;
        inc_k  = lp.loop_exit & ~lp.loop_last_iter;

        // lowest priority first so higher-priority rules overwrite
        cur_d = cur_q;
        if (inc_0)
            cur_d[0] = sum_0[ADDR_W-1:0];
        if (inc_k)
            cur_d[k] = sum_k[ADDR_W-1:0];
        if (lp.loop_enter && !lp.loop_init && k_nz)
            cur_d[km1] = cur_q[k];
        if (lp.loop_init) begin
            cur_d[k] = base_q;
            if (k_nz)
                cur_d[km1] = base_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                stride_q[i] <= '0;
                cur_q[i]    <= '0;
            end
        end else begin
            if (cfg_base_addr_v)
                base_q <= cfg_base_addr;
            if (cfg_stride_v)
                stride_q[cfg_stride_loop_id] <= cfg_stride;
            for (int i = 0; i < NUM_LOOPS; i++)
                cur_q[i] <= cur_d[i];
        end
    end

`ifdef ADDR_BOUNDS_CHECK_EN
    logic [ADDR_W-1:0] limit_q;
    logic              oob_q;
    logic              wrap;

    // carry-out means wrap for a positive stride; missing carry means underflow for a negative one
    always_comb begin
        wrap = 1'b0;
        if (inc_0 && (sum_0[ADDR_W] ^ sext_0[ADDR_W-1]))
            wrap = 1'b1;
        if (inc_k && (sum_k[ADDR_W] ^ sext_k[ADDR_W-1]))
            wrap = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limit_q <= '1;
            oob_q   <= 1'b0;
        end else begin
            if (cfg_addr_limit_v)
                limit_q <= cfg_addr_limit;
            if (lp.loop_init)
                oob_q <= 1'b0;
            else if ((lp.addr_out_v && lp.addr_out_ready && (cur_q[0] > limit_q)) || wrap)
                oob_q <= 1'b1;
        end
    end

    assign addr_oob = oob_q;
`endif
endmodule

// File: doc/loop_stride_addr_gen.md
Name: loop_stride_addr_gen

Overview:
- Address generator sitting directly downstream of the loop controller FSM.
- Consumes the controller's per-cycle loop events (loop_index, init/enter/exit, last_iter, index_valid) and turns them into a strided memory address stream: addr = base + sum over loops k of (iter_k * stride_k).
- Keeps one running address per loop level and updates it incrementally on each loop event.
- Applies consumer backpressure to the loop controller through its stall output.

Parameters:
- LOOP_ID_W, 5, loop index width; NUM_LOOPS = 2^LOOP_ID_W.
- ADDR_W, 32, address width; all address arithmetic is modulo 2^ADDR_W.
- STRIDE_W, 16, signed stride width; sign-extended to ADDR_W before adding.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_base_addr_v  in  1  base address write strobe.
- cfg_base_addr  in  ADDR_W  base address.
- cfg_stride_v  in  1  stride write strobe.
- cfg_stride  in  STRIDE_W  signed stride.
- cfg_stride_loop_id  in  LOOP_ID_W  loop level the stride belongs to.
- loop_index  in  LOOP_ID_W  current loop level from the controller.
- loop_index_valid  in  1  controller is in its innermost-iteration state (level 0).
- loop_init  in  1  initial descent after start.
- loop_enter  in  1  descent into a loop (also high during init).
- loop_exit  in  1  outer-loop increment/exit cycle.
- loop_last_iter  in  1  iteration count of loop_index equals its max.
- stall  out  1  backpressure to the controller.
- addr_out  out  ADDR_W  generated address.
- addr_out_v  out  1  address valid.
- addr_out_ready  in  1  consumer accepts the address.

Behaviour:
- Storage:
  - stride_q[NUM_LOOPS] registers, STRIDE_W bits.
  - cur_q[NUM_LOOPS] registers, ADDR_W bits.
  - base_q register, ADDR_W bits.
  - Reset clears all of them, so addr_out = 0, addr_out_v = 0, stall = 0 (plus addr_oob = 0 when the optional feature is built).
- Config:
  - cfg_stride_v writes stride_q[cfg_stride_loop_id]; cfg_base_addr_v writes base_q.
  - Writes are registered. A same-cycle consumer of a slot sees the old value.
  - Config is legal only while the controller is idle. Mid-run writes are applied unguarded.
- Outputs (combinational from registers; zero latency relative to the controller state):
  - addr_out = cur_q[0].
  - addr_out_v = loop_index_valid.
  - stall = addr_out_v & ~addr_out_ready.
- Update rules per cycle (priority order; k = loop_index):
  1. loop_init: cur_q[k] <= base_q. If k != 0, also cur_q[k-1] <= base_q.
  2. loop_enter & ~loop_init: if k != 0, cur_q[k-1] <= cur_q[k] (restart inner loop at the current outer position).
  3. loop_exit & ~loop_last_iter: cur_q[k] <= cur_q[k] + sext(stride_q[k]).
     - loop_exit & loop_last_iter: no update. The level is overwritten on re-entry.
  4. loop_index_valid & addr_out_ready:
     - If ~loop_last_iter: cur_q[0] <= cur_q[0] + sext(stride_q[0]).
     - If loop_last_iter: cur_q[0] holds.
     - With addr_out_ready low, cur_q[0] holds and the address is re-presented.
- Handshake: an address is transferred on addr_out_v & addr_out_ready. Exactly one transfer occurs per innermost iteration.
- Event gating: enter/init/exit events are never gated by stall, matching the controller.
- Wrap-around: sums wrap modulo 2^ADDR_W with no flag (except the optional check below). Negative strides are supported.
- Single-loop case (max loop ptr 0): only the init write to cur_q[0] and rule 4 apply.
- Reset mid-operation: all state clears asynchronously and addr_out_v drops immediately. The controller is reset in the same domain.

Optional Feature:
- Macro: ADDR_BOUNDS_CHECK_EN.
- Defined:
  - Adds input cfg_addr_limit_v (1 bit) and input cfg_addr_limit (ADDR_W); the limit register resets to all-ones.
  - Adds output addr_oob (1 bit), a sticky flag set when a transfer occurs with addr_out > limit, or when any cur_q update wraps past 2^ADDR_W.
  - addr_oob is cleared only by reset or by a loop_init cycle.
- Undefined: those ports and the flag are absent. Wrap is silent.

Test Plan:
- Single loop, max=3, stride0=4, base=0x100, ready=1 -> addresses 0x100, 0x104, 0x108, 0x10C, then addr_out_v low.
- Two loops, max0=1, max1=2, stride0=1, stride1=16, base=0 -> 0, 1, 16, 17, 32, 33.
- Same as the previous scenario with ready low for 3 cycles on the second address -> stall high for 3 cycles, addr_out stuck at 1, sequence unchanged.
- Three loops, stride2=-64, stride1=8, stride0=1, maxes 1/1/1, base=0x1000 -> 0x1000, 0x1001, 0x1008, 0x1009, 0xFC0, 0xFC1, 0xFC8, 0xFC9.
- Reset asserted during the second outer iteration -> outputs zero immediately; a rerun from start reproduces the full sequence from base.
- With ADDR_BOUNDS_CHECK_EN, limit=0x10A, run the first scenario -> addr_oob rises on transfer of 0x10C and stays high until the next loop_init.
